usb_tx_scheduler: RTL and testbench
===================================

Name: usb_tx_scheduler

Overview:
- Sequences the USB transmit timer/shifter for the miner's outbound link.
- Arbitrates between two packet sources, round-robin:
  - port A: status/ack frames, STATUS_BYTES long.
  - port B: result/nonce frames, RESULT_BYTES long.
- Drives the timer's transmitting and transmit_empty (short-frame select) and feeds bytes to the shifter.
- Detects stalled or mis-framed transmissions.

Parameters:
STATUS_BYTES, 3, byte count of a port-A frame (matches timer short-frame length)
RESULT_BYTES, 17, byte count of a port-B frame (matches timer long-frame length)
TIMEOUT, 255, max cycles allowed between consecutive byte_sent pulses before abort

Ports:
clk  input  1  system clock
n_rst  input  1  synchronous active-low reset
req_a  input  1  port A frame ready; level, held until done_a or err
req_b  input  1  port B frame ready; level, held until done_b or err
data_a  input  8  port A byte at rd_idx (combinational from source)
data_b  input  8  port B byte at rd_idx
byte_sent  input  1  timer pulse: one byte fully shifted
data_sent  input  1  timer pulse: whole frame shifted
rd_idx  output  5  byte index presented to the granted source
gnt_a  output  1  port A owns the transmitter
gnt_b  output  1  port B owns the transmitter
tx_data  output  8  byte to shifter, registered
tx_load  output  1  one-cycle pulse: shifter loads tx_data
transmitting  output  1  timer enable; low clears timer counters
transmit_empty  output  1  1 = short (port A) frame, 0 = long frame
done_a  output  1  one-cycle pulse: port A frame completed
done_b  output  1  one-cycle pulse: port B frame completed
err  output  1  one-cycle pulse: timeout or byte-count mismatch

Behaviour:
- Reset (n_rst low at posedge):
  - state IDLE.
  - All outputs 0, except transmit_empty = 1.
  - last_grant = B, so A wins the first tie.
  - rd_idx = 0.
  - Reset mid-frame aborts immediately; no done or err is produced.
- States: IDLE, LOAD, SEND, DONE, ABORT.
- IDLE:
  - No request: stay.
  - One request: grant it.
  - Both requesting: grant the port not in last_grant.
  - Grant is registered (gnt_x and last_grant update) and the next state is LOAD.
  - rd_idx = 0.
  - transmit_empty = 1 when A is granted, 0 when B is granted; held for the whole frame.
- LOAD (1 cycle):
  - tx_data <= granted data at rd_idx 0.
  - tx_load = 1 in the following cycle.
  - transmitting = 1 from the following cycle onward.
  - Next state SEND.
- SEND:
  - On byte_sent:
    - bytes_done++.
    - If bytes_done < len, rd_idx++, tx_data <= next byte, and tx_load pulses one cycle later.
    - The final byte_sent does not load.
  - On data_sent (same cycle as a byte_sent is legal; count the byte first):
    - bytes_done == len → DONE.
    - Otherwise → err pulse, then ABORT.
  - Watchdog: resets on every byte_sent and on entering SEND. Reaching TIMEOUT → ABORT with an err pulse.
  - byte_sent after bytes_done == len (no data_sent): err, ABORT.
- DONE (1 cycle):
  - transmitting = 0.
  - Granted done_x pulses; gnt_x clears.
  - Next state IDLE.
- ABORT (1 cycle):
  - transmitting = 0, which clears the timer; gnt_x clears.
  - No done pulse; the requester keeps req and is re-arbitrated.
  - last_grant stays the aborted port, so the other port wins a tie.
  - Next state IDLE.
- Minimum idle between frames: one IDLE cycle with transmitting low.
- req changes during a frame are ignored; the grant is fixed until DONE/ABORT.
- byte_sent/data_sent outside SEND are ignored.
- Widths:
  - rd_idx and bytes_done are 5-bit; lengths must be ≤ 31.
  - The watchdog counter is ceil(log2(TIMEOUT+1)) bits and saturates; no wrap.
- Outputs are registered except gnt-derived transmit_empty.

Test Plan:
- Port A alone:
  - Stimulus: req_a=1; timer model pulses byte_sent every 128 cycles, data_sent with the 3rd.
  - Response: gnt_a, transmit_empty=1, tx_load ×3 with data_a[0..2], done_a one pulse, transmitting low one cycle after data_sent.
- Simultaneous requests:
  - Stimulus: req_a=req_b=1 from reset.
  - Response: A served first (3 bytes); B granted next (17 bytes, transmit_empty=0); with both still requesting, A follows.
- Stall:
  - Stimulus: grant B, send 5 bytes, then no byte_sent for TIMEOUT cycles.
  - Response: err pulse, transmitting drops for 1 cycle, no done_b; A granted next if requesting.
- Mis-framed frame:
  - Stimulus: grant A, assert data_sent after the 2nd byte_sent.
  - Response: err, no done_a, re-grant.
- Reset mid-frame:
  - Stimulus: n_rst low during B byte 9.
  - Response: all outputs at reset values at that edge; next frame restarts with rd_idx=0.
- Request drop:
  - Stimulus: req_b deasserted mid-frame.
  - Response: frame completes, done_b pulses.

Source files
------------

// File: rtl/usb_tx_scheduler.sv
// usb_tx_scheduler: round-robin two-port frame scheduler driving the USB transmit timer/shifter.
// Ports: clk/n_rst (sync active-low); req_a/req_b frame requests; data_a/data_b source bytes at rd_idx;
// byte_sent/data_sent timer pulses; rd_idx byte index; gnt_a/gnt_b ownership; tx_data/tx_load shifter feed;
// transmitting/transmit_empty timer controls; done_a/done_b completion pulses; err abort pulse.
module usb_tx_scheduler #(
  parameter int STATUS_BYTES = 3,
  parameter int RESULT_BYTES = 17,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  input  logic       byte_sent,
  input  logic       data_sent,
  output logic [4:0] rd_idx,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic [7:0] tx_data,
  output logic       tx_load,
  output logic       transmitting,
  output logic       transmit_empty,
  output logic       done_a,
  output logic       done_b,
  output logic       err
);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE, ABORT} state_t;
  state_t state, state_n;
  logic last_b, fetch, pick_a, fail;
  logic [4:0] bytes_done, cnt, len;
  logic [WW-1:0] wd, wd_n;
  logic [7:0] data;
  assign len = gnt_a ? 5'(STATUS_BYTES) : 5'(RESULT_BYTES);
  assign data = gnt_a ? data_a : data_b;
  assign transmit_empty = ~gnt_b;
  // A wins unless B also requests and A held the previous grant
  assign pick_a = req_a & (~req_b | last_b);
  // a byte_sent coinciding with data_sent is counted before the frame length is judged
  assign cnt = bytes_done + 5'(byte_sent);
  assign wd_n = wd + WW'(wd != WW'(TIMEOUT));
  always_comb begin
    state_n = state;
    fail = 1'b0;
    case (state)
      IDLE: state_n = (req_a | req_b) ? LOAD : IDLE;
      LOAD: state_n = SEND;
      SEND: begin
        fail = data_sent ? (cnt != len) : byte_sent ? (bytes_done == len) : (wd_n == WW'(TIMEOUT));
        state_n = fail ? ABORT : data_sent ? DONE : SEND;
      end
      default: state_n = IDLE;
    endcase
  end
  // a byte index advanced on byte_sent is fetched from the source one cycle later (fetch)
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      last_b <= 1'b1;
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      rd_idx <= '0;
      bytes_done <= '0;
      wd <= '0;
      fetch <= 1'b0;
      tx_data <= '0;
      tx_load <= 1'b0;
      transmitting <= 1'b0;
      done_a <= 1'b0;
      done_b <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      tx_load <= 1'b0;
      done_a <= 1'b0;
      done_b <= 1'b0;
      err <= fail;
      case (state)
        IDLE: if (req_a | req_b) begin
          gnt_a <= pick_a;
          gnt_b <= ~pick_a;
          last_b <= ~pick_a;
        end
        LOAD: begin
          tx_data <= data;
          tx_load <= 1'b1;
          transmitting <= 1'b1;
          bytes_done <= '0;
          wd <= '0;
          fetch <= 1'b0;
        end
        SEND: if (state_n != SEND) begin
          transmitting <= 1'b0;
          done_a <= gnt_a & ~fail;
          done_b <= gnt_b & ~fail;
          rd_idx <= '0;
          fetch <= 1'b0;
        end else begin
          wd <= byte_sent ? '0 : wd_n;
          if (byte_sent) bytes_done <= cnt;
          fetch <= byte_sent & (cnt < len);
          if (byte_sent & (cnt < len)) rd_idx <= rd_idx + 5'd1;
          if (fetch) begin
            tx_data <= data;
            tx_load <= 1'b1;
          end
        end
        default: begin
          gnt_a <= 1'b0;
          gnt_b <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_usb_tx_scheduler.sv
// tb_usb_tx_scheduler: plays source and transmit timer around usb_tx_scheduler and checks frames.
// Ports: none (top-level bench).
module tb_usb_tx_scheduler;
  localparam int SB = 3, RB = 17, TO = 255;
  logic clk = 0, n_rst = 0, req_a = 0, req_b = 0, byte_sent = 0, data_sent = 0;
  logic [7:0] data_a, data_b, tx_data;
  logic [4:0] rd_idx;
  logic gnt_a, gnt_b, tx_load, transmitting, transmit_empty, done_a, done_b, err;
  logic [7:0] pa [32];
  logic [7:0] pb [32];
  int checks = 0, failures = 0;
  bit last_a = 0;
  assign data_a = pa[rd_idx];
  assign data_b = pb[rd_idx];
  always #5 clk = ~clk;
  usb_tx_scheduler dut (
    .clk(clk), .n_rst(n_rst), .req_a(req_a), .req_b(req_b), .data_a(data_a), .data_b(data_b),
    .byte_sent(byte_sent), .data_sent(data_sent), .rd_idx(rd_idx), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .tx_data(tx_data), .tx_load(tx_load), .transmitting(transmitting), .transmit_empty(transmit_empty),
    .done_a(done_a), .done_b(done_b), .err(err)
  );
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_reset();
    chk("rst_gnt", {gnt_a, gnt_b}, 0);
    chk("rst_pulses", {tx_load, done_a, done_b, err}, 0);
    chk("rst_transmitting", transmitting, 0);
    chk("rst_transmit_empty", transmit_empty, 1);
    chk("rst_rd_idx", rd_idx, 0);
    chk("rst_tx_data", tx_data, 0);
  endtask
  function automatic bit pick();
    return req_a && (!req_b || !last_a);
  endfunction
  // mode 0: full frame; 1: data_sent with byte k; 2: silence after byte k; 3: reset while byte k is out
  task automatic serve(input int mode, input int k, input bit drop_b);
    bit a;
    int len, n, w;
    a = pick();
    len = a ? SB : RB;
    for (int i = 0; i < 32; i++) begin
      if (a) pa[i] = 8'($urandom);
      else pb[i] = 8'($urandom);
    end
    w = 0;
    while (!(gnt_a || gnt_b) && w < 20) begin tick(); w++; end
    chk("grant_a", gnt_a, a);
    chk("grant_b", gnt_b, !a);
    chk("transmit_empty", transmit_empty, a);
    last_a = a;
    n = (mode == 0) ? len : k;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!tx_load && w < 10) begin tick(); w++; end
      chk("tx_load_seen", tx_load, 1);
      chk("tx_data", tx_data, a ? pa[i] : pb[i]);
      chk("transmitting_high", transmitting, 1);
      if (mode == 3 && i == k - 1) begin
        n_rst = 0;
        tick();
        chk_reset();
        n_rst = 1;
        last_a = 0;
        return;
      end
      repeat ($urandom_range(2, 12)) tick();
      if (drop_b && i == 3) req_b = 0;
      byte_sent = 1;
      data_sent = (i == n - 1) && (mode < 2);
      tick();
      byte_sent = 0;
      data_sent = 0;
    end
    if (mode == 2) begin
      w = 0;
      while (!err && w < TO + 10) begin tick(); w++; end
      chk("stall_err_time", (w >= TO - 1 && w <= TO + 1), 1);
    end
    chk(mode == 0 ? "done_a_pulse" : "abort_no_done_a", done_a, mode == 0 && a);
    chk(mode == 0 ? "done_b_pulse" : "abort_no_done_b", done_b, mode == 0 && !a);
    chk("err_pulse", err, mode != 0);
    chk("transmitting_low", transmitting, 0);
    chk("no_load_after_end", tx_load, 0);
    if (mode == 0) begin
      if (a) req_a = 0;
      else req_b = 0;
    end
    tick();
    chk("gnt_clear", {gnt_a, gnt_b}, 0);
    chk("pulses_one_cycle", {done_a, done_b, err}, 0);
    chk("idle_transmitting", transmitting, 0);
  endtask
  initial begin
    req_a = 1;
    req_b = 1;
    repeat (3) tick();
    chk_reset();
    n_rst = 1;
    last_a = 0;
    serve(0, 0, 0);
    req_a = 1;
    serve(0, 0, 0);
    req_b = 1;
    serve(0, 0, 0);
    req_a = 1;
    serve(2, 5, 0);
    serve(0, 0, 0);
    serve(0, 0, 0);
    req_a = 1;
    serve(1, 2, 0);
    serve(0, 0, 0);
    req_b = 1;
    serve(3, 9, 0);
    serve(0, 0, 0);
    req_b = 1;
    serve(0, 0, 1);
    for (int r = 0; r < 8; r++) begin
      req_a = 1'($urandom);
      req_b = 1'($urandom);
      if (!req_a && !req_b) req_b = 1;
      serve(int'($urandom_range(0, 1)), int'($urandom_range(1, 2)), 0);
    end
    req_a = 0;
    req_b = 0;
    repeat (3) tick();
    byte_sent = 1;
    data_sent = 1;
    tick();
    byte_sent = 0;
    data_sent = 0;
    tick();
    chk("idle_ignore_err", err, 0);
    chk("idle_ignore_gnt", {gnt_a, gnt_b}, 0);
    chk("idle_ignore_tx", {transmitting, tx_load}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
